// File: rtl/instruction_sequencer.sv
// Program sequencer: steps an internal program RAM with one hardware loop
// and drives the registered 17-bit instruction word onto the cores.
module instruction_sequencer #(
   parameter int PROG_AW = 8,
   parameter int LOOP_W  = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               prog_we_i,
   input  logic [PROG_AW-1:0] prog_addr_i,
   input  logic [18:0]        prog_data_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [LOOP_W-1:0]  loop_count_i,
   output logic [16:0]        instruction_o,
   output logic               valid_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);

   localparam logic [1:0] C_ISSUE = 2'b00;
   localparam logic [1:0] C_LSTART = 2'b01;
   localparam logic [1:0] C_LEND = 2'b10;
   localparam logic [1:0] C_HALT = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_t;

   state_t state, state_d;

   logic [18:0] mem [2**PROG_AW];
   logic [18:0] mem_q;
   logic [PROG_AW-1:0] q_addr;
   logic [PROG_AW-1:0] pc, pc_d;
   logic [PROG_AW-1:0] loop_addr, loop_addr_d;
   logic [LOOP_W-1:0] loop_cnt, loop_cnt_d;
   logic skip, skip_d;
   logic [16:0] instr_d;
   logic valid_d, done_d, err_d;
   logic wr_en, taken;

   assign wr_en = prog_we_i && (state == IDLE);
   assign busy_o = (state == PRIME) || (state == RUN);

   // Write-first forwarding lets a same-edge write to pc reach mem_q.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[prog_addr_i] <= prog_data_i;
      end
      if (wr_en && (prog_addr_i == pc)) begin
         mem_q <= prog_data_i;
      end else begin
         mem_q <= mem[pc];
      end
      q_addr <= pc;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         pc <= '0;
         loop_addr <= '0;
         loop_cnt <= '0;
         skip <= 1'b0;
         instruction_o <= '0;
         valid_o <= 1'b0;
         done_o <= 1'b0;
         err_o <= 1'b0;
      end else begin
         state <= state_d;
         pc <= pc_d;
         loop_addr <= loop_addr_d;
         loop_cnt <= loop_cnt_d;
         skip <= skip_d;
         instruction_o <= instr_d;
         valid_o <= valid_d;
         done_o <= done_d;
         err_o <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      pc_d = pc;
      loop_addr_d = loop_addr;
      loop_cnt_d = loop_cnt;
      skip_d = 1'b0;
      instr_d = '0;
      valid_d = 1'b0;
      done_d = 1'b0;
      err_d = err_o;
      taken = 1'b0;
      if (abort_i) begin
         state_d = IDLE;
         pc_d = '0;
      end else begin
         case (state)
            IDLE: begin
               pc_d = '0;
               if (start_i) begin
                  state_d = PRIME;
                  loop_cnt_d = loop_count_i;
                  loop_addr_d = '0;
                  err_d = 1'b0;
               end
            end
            PRIME: begin
               pc_d = PROG_AW'(1);
               state_d = RUN;
            end
            RUN: begin
               if (skip) begin
                  // stale word fetched behind a taken loop end
                  pc_d = pc + PROG_AW'(1);
               end else if (mem_q[18:17] == C_HALT) begin
                  done_d = 1'b1;
                  state_d = IDLE;
                  pc_d = '0;
               end else begin
                  instr_d = mem_q[16:0];
                  valid_d = 1'b1;
                  pc_d = pc + PROG_AW'(1);
                  if (mem_q[18:17] == C_LSTART) begin
                     loop_addr_d = q_addr;
                  end
                  if (mem_q[18:17] == C_LEND && loop_cnt != '0) begin
                     taken = 1'b1;
                     loop_cnt_d = loop_cnt - LOOP_W'(1);
                     pc_d = loop_addr;
                     skip_d = 1'b1;
                  end
                  if (!taken && (q_addr == '1)) begin
                     err_d = 1'b1;
                     done_d = 1'b1;
                     state_d = IDLE;
                     pc_d = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               pc_d = '0;
            end
         endcase
      end
   end

   logic unused;
   assign unused = ^{C_ISSUE};

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: expected stream queued
// before each run and popped one entry per cycle of output.
module tb_instruction_sequencer;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic prog_we_i = 1'b0;
   logic [7:0] prog_addr_i = '0;
   logic [18:0] prog_data_i = '0;
   logic start_i = 1'b0;
   logic abort_i = 1'b0;
   logic [15:0] loop_count_i = '0;
   logic [16:0] instruction_o;
   logic valid_o, busy_o, done_o, err_o;

   instruction_sequencer #(.PROG_AW(8), .LOOP_W(16)) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .prog_we_i(prog_we_i),
      .prog_addr_i(prog_addr_i),
      .prog_data_i(prog_data_i),
      .start_i(start_i),
      .abort_i(abort_i),
      .loop_count_i(loop_count_i),
      .instruction_o(instruction_o),
      .valid_o(valid_o),
      .busy_o(busy_o),
      .done_o(done_o),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic v;
      logic [16:0] w;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   localparam logic [16:0] WA = 17'h00101;
   localparam logic [16:0] WB = 17'h01282;
   localparam logic [16:0] WC = 17'h02383;
   localparam logic [16:0] WD = 17'h13004;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [1:0] c,
                       input logic [16:0] w);
      prog_we_i = 1'b1;
      prog_addr_i = a;
      prog_data_i = {c, w};
      tick();
      prog_we_i = 1'b0;
   endtask

   task automatic push(input logic v, input logic [16:0] w);
      exp_t e;
      e.v = v;
      e.w = w;
      q.push_back(e);
   endtask

   task automatic load_loop_prog();
      load(8'd0, 2'b00, WA);
      load(8'd1, 2'b01, WB);
      load(8'd2, 2'b10, WC);
      load(8'd3, 2'b00, WD);
      load(8'd4, 2'b11, 17'h1ffff);
   endtask

   task automatic push_loop(input int n);
      push(1'b1, WA);
      for (int i = 0; i <= n; i++) begin
         push(1'b1, WB);
         push(1'b1, WC);
         if (i < n) push(1'b0, 17'h0);
      end
      push(1'b1, WD);
   endtask

   task automatic run_stream(input string name, input logic [15:0] n,
                             input bit runoff, input bit we_on_start,
                             input bit poke_busy, input logic [18:0] wdata);
      exp_t e;
      logic want_done;
      loop_count_i = n;
      start_i = 1'b1;
      if (we_on_start) begin
         prog_we_i = 1'b1;
         prog_addr_i = 8'd0;
         prog_data_i = wdata;
      end
      tick();
      start_i = 1'b0;
      prog_we_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b1 || err_o !== 1'b0 || valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s prime: busy=%0b err=%0b valid=%0b want 1 0 0",
                  name, busy_o, err_o, valid_o);
      end
      if (poke_busy) begin
         start_i = 1'b1;
         prog_we_i = 1'b1;
         prog_addr_i = 8'd0;
         prog_data_i = wdata;
         loop_count_i = 16'hffff;
      end
      tick();
      start_i = 1'b0;
      prog_we_i = 1'b0;
      while (q.size() > 0) begin
         tick();
         e = q.pop_front();
         want_done = runoff && (q.size() == 0);
         vectors++;
         if ({valid_o, instruction_o} !== e || done_o !== want_done) begin
            miscompares++;
            $display("FAIL %s stream: got v=%0b w=%05h d=%0b want v=%0b w=%05h d=%0b",
                     name, valid_o, instruction_o, done_o, e.v, e.w, want_done);
         end
      end
      if (!runoff) begin
         tick();
         vectors++;
         if (done_o !== 1'b1 || valid_o !== 1'b0 || instruction_o !== 17'h0) begin
            miscompares++;
            $display("FAIL %s halt: done=%0b valid=%0b w=%05h want 1 0 00000",
                     name, done_o, valid_o, instruction_o);
         end
      end else begin
         vectors++;
         if (err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s err: got %0b want 1", name, err_o);
         end
      end
      tick();
      vectors++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s idle: busy=%0b done=%0b valid=%0b want 0 0 0",
                  name, busy_o, done_o, valid_o);
      end
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({instruction_o, valid_o, busy_o, done_o, err_o} !== 21'h0) begin
         miscompares++;
         $display("FAIL reset: got w=%05h v=%0b b=%0b d=%0b e=%0b want all 0",
                  instruction_o, valid_o, busy_o, done_o, err_o);
      end
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      load(8'd0, 2'b00, 17'h00081);
      load(8'd1, 2'b00, 17'h01200);
      load(8'd2, 2'b11, 17'h0abcd);
      push(1'b1, 17'h00081);
      push(1'b1, 17'h01200);
      run_stream("t1_basic", 16'd0, 1'b0, 1'b0, 1'b0, 19'h0);
   endtask

   task automatic test_write_first();
      push(1'b1, 17'h00555);
      push(1'b1, 17'h01200);
      run_stream("write_first", 16'd0, 1'b0, 1'b1, 1'b0, {2'b00, 17'h00555});
   endtask

   task automatic test_loop();
      load_loop_prog();
      push_loop(2);
      run_stream("t2_loop2", 16'd2, 1'b0, 1'b0, 1'b0, 19'h0);
      push_loop(0);
      run_stream("t3_loop0", 16'd0, 1'b0, 1'b0, 1'b0, 19'h0);
   endtask

   task automatic test_runoff();
      logic [16:0] w;
      for (int i = 0; i < 256; i++) begin
         w = 17'(i * 40503 + 7);
         load(8'(i), 2'b00, w);
         push(1'b1, w);
      end
      run_stream("t4_runoff", 16'd0, 1'b1, 1'b0, 1'b0, 19'h0);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      vectors++;
      if (err_o !== 1'b0 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL t4_clear: err=%0b busy=%0b want 0 1", err_o, busy_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b0 || err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL t4_abort: busy=%0b err=%0b want 0 0", busy_o, err_o);
      end
   endtask

   task automatic test_abort();
      load_loop_prog();
      loop_count_i = 16'd2;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      vectors++;
      if (instruction_o !== 17'h0 || valid_o !== 1'b0 || busy_o !== 1'b0 ||
          done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL t5_abort: w=%05h v=%0b b=%0b d=%0b want 0 0 0 0",
                  instruction_o, valid_o, busy_o, done_o);
      end
      tick();
      vectors++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL t5_nodone: done=%0b busy=%0b want 0 0", done_o, busy_o);
      end
      push_loop(1);
      run_stream("t5_restart", 16'd1, 1'b0, 1'b0, 1'b0, 19'h0);
   endtask

   task automatic test_busy_ignore();
      push_loop(0);
      run_stream("t6_poke", 16'd0, 1'b0, 1'b0, 1'b1, {2'b11, 17'h0});
      push_loop(0);
      run_stream("t6_ram", 16'd0, 1'b0, 1'b0, 1'b0, 19'h0);
      loop_count_i = 16'd2;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      tick();
      #2;
      rst_ni = 1'b0;
      #1;
      vectors++;
      if ({instruction_o, valid_o, busy_o, done_o, err_o} !== 21'h0) begin
         miscompares++;
         $display("FAIL t6_async_rst: w=%05h v=%0b b=%0b d=%0b e=%0b want 0",
                  instruction_o, valid_o, busy_o, done_o, err_o);
      end
      tick();
      rst_ni = 1'b1;
      tick();
      push_loop(2);
      run_stream("t6_after_rst", 16'd2, 1'b0, 1'b0, 1'b0, 19'h0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_write_first();
      test_loop();
      test_runoff();
      test_abort();
      test_busy_ignore();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
